trap_sequencer: RTL and testbench

//  Multi-cycle controller that sequences the machine-mode CSR/exception unit.

---
 rtl/trap_sequencer_pkg.sv | 36 +++
 rtl/trap_sequencer_if.sv | 46 ++++
 rtl/trap_sequencer_prio_arbiter.sv | 41 ++++
 rtl/trap_sequencer.sv | 151 +++++++++++++++
 tb/tb_trap_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// trap_sequencer_pkg
//  Shared constants for the machine-mode trap sequencer:
//   - default widths (exception sources, cause code, data/address)
//   - CSR write addresses used by the trap sequence
//   - FSM state encodings
//   - redirect-kind type (trap entry vs. MRET return)
// ---------------------------------------------------------------------------
package trap_sequencer_pkg;

    localparam int NUM_SRC_DEF = 3;
    localparam int CAUSE_W_DEF = 5;
    localparam int XLEN_DEF    = 32;

    localparam int CSR_ADDR_W = 12;

    localparam logic [CSR_ADDR_W-1:0] CSR_MEPC   = 12'h341;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE = 12'h342;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVAL  = 12'h343;

    // FSM encodings kept as plain constants so they match the legacy
    // encodings used by the surrounding CSR unit.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_KILL    = 3'd1;
    localparam logic [2:0] ST_W_EPC   = 3'd2;
    localparam logic [2:0] ST_W_CAUSE = 3'd3;
    localparam logic [2:0] ST_W_TVAL  = 3'd4;
    localparam logic [2:0] ST_REDIR   = 3'd5;

    // What the REDIR state is redirecting for.
    typedef enum logic {
        REDIR_TRAP = 1'b0,
        REDIR_MRET = 1'b1
    } redir_kind_e;

endpackage

// File: rtl/trap_sequencer_if.sv
// ---------------------------------------------------------------------------
// trap_sequencer_if
//  Bundle between the pipeline / CSR file and the trap sequencer.
//  master: pipeline + CSR side (drives requests and current CSR values)
//  slave : trap sequencer (drives CSR write port and pipeline control)
//   exc_valid/exc_cause/exc_pc/exc_tval : per-source exception requests (packed)
//   mret_valid                          : MRET retiring in execute
//   csr_mtvec/csr_mepc                  : current CSR values
//   csr_we/csr_waddr/csr_wdata          : CSR write port, one write per cycle
//   stall/flush/redirect/redirect_addr  : pipeline control
//   busy                                : sequence in progress
// ---------------------------------------------------------------------------
interface trap_sequencer_if
    import trap_sequencer_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int CAUSE_W = CAUSE_W_DEF,
    parameter int XLEN    = XLEN_DEF
);
    logic [NUM_SRC-1:0]         exc_valid;
    logic [NUM_SRC*CAUSE_W-1:0] exc_cause;
    logic [NUM_SRC*XLEN-1:0]    exc_pc;
    logic [NUM_SRC*XLEN-1:0]    exc_tval;
    logic                       mret_valid;
    logic [XLEN-1:0]            csr_mtvec;
    logic [XLEN-1:0]            csr_mepc;

    logic                       csr_we;
    logic [CSR_ADDR_W-1:0]      csr_waddr;
    logic [XLEN-1:0]            csr_wdata;
    logic                       stall;
    logic                       flush;
    logic                       redirect;
    logic [XLEN-1:0]            redirect_addr;
    logic                       busy;

    modport master (
        output exc_valid, exc_cause, exc_pc, exc_tval, mret_valid, csr_mtvec, csr_mepc,
        input  csr_we, csr_waddr, csr_wdata, stall, flush, redirect, redirect_addr, busy
    );

    modport slave (
        input  exc_valid, exc_cause, exc_pc, exc_tval, mret_valid, csr_mtvec, csr_mepc,
        output csr_we, csr_waddr, csr_wdata, stall, flush, redirect, redirect_addr, busy
    );
endinterface

// File: rtl/trap_sequencer_prio_arbiter.sv
// ---------------------------------------------------------------------------
// trap_prio_arbiter
//  Fixed-priority picker: the highest set index of valid_i wins (the highest
//  index is the oldest pipeline stage, so it must trap first).
//   valid_i : per-source request
//   grant_o : one-hot grant (all zero when no request)
//   idx_o   : index of the granted source (0 when no request)
// ---------------------------------------------------------------------------
module trap_prio_arbiter
    import trap_sequencer_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] valid_i,
    output logic [NUM_SRC-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_grant
            if (gi == NUM_SRC - 1) begin : g_top
                assign grant_o[gi] = valid_i[gi];
            end else begin : g_lower
                // A source wins only if no older (higher-index) source requests.
                assign grant_o[gi] = valid_i[gi] & ~(|valid_i[NUM_SRC-1:gi+1]);
            end
        end
    endgenerate

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_o[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// ---------------------------------------------------------------------------
// trap_sequencer
//  Multi-cycle controller for the machine-mode CSR/exception unit.
//  Accepts the oldest pending exception (or an MRET) while idle, then:
//    KILL    : flush + stall the pipe
//    W_EPC   : write mepc   (latched faulting PC)
//    W_CAUSE : write mcause (latched cause, zero-extended, interrupt bit 0)
//    W_TVAL  : write mtval  (latched trap value)
//    REDIR   : redirect fetch to mtvec (direct mode) and flush
//  An MRET goes straight to REDIR and redirects to mepc.
//  Ports:
//   clk   : core clock
//   reset : synchronous, active-high
//   bus   : trap_sequencer_if.slave (requests in, CSR write / pipe control out)
// ---------------------------------------------------------------------------
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int CAUSE_W = CAUSE_W_DEF,
    parameter int XLEN    = XLEN_DEF
) (
    input  logic             clk,
    input  logic             reset,
    trap_sequencer_if.slave  bus
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [2:0]         state_q, state_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [XLEN-1:0]    pc_q,    pc_d;
    logic [XLEN-1:0]    tval_q,  tval_d;
    redir_kind_e        kind_q,  kind_d;

    logic [NUM_SRC-1:0] grant;
    logic [IDX_W-1:0]   win_idx;
    logic               any_exc;

    // Low bits of mtvec/mepc are masked off the redirect target by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.csr_mtvec[1:0], bus.csr_mepc[0]};

    trap_prio_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_arb (
        .valid_i (bus.exc_valid),
        .grant_o (grant),
        .idx_o   (win_idx)
    );

    assign any_exc = |grant;

    // Next-state and capture logic. Requests are only looked at in IDLE;
    // everywhere else the pipe is stalled or being flushed.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        tval_d  = tval_q;
        kind_d  = kind_q;
        case (state_q)
            ST_IDLE: begin
                if (any_exc) begin
                    // Exception beats a simultaneous MRET; the MRET is dropped.
                    state_d = ST_KILL;
                    kind_d  = REDIR_TRAP;
                    cause_d = bus.exc_cause[win_idx*CAUSE_W +: CAUSE_W];
                    pc_d    = bus.exc_pc[win_idx*XLEN +: XLEN];
                    tval_d  = bus.exc_tval[win_idx*XLEN +: XLEN];
                end else if (bus.mret_valid) begin
                    state_d = ST_REDIR;
                    kind_d  = REDIR_MRET;
                end
            end
            ST_KILL:    state_d = ST_W_EPC;
            ST_W_EPC:   state_d = ST_W_CAUSE;
            ST_W_CAUSE: state_d = ST_W_TVAL;
            ST_W_TVAL:  state_d = ST_REDIR;
            ST_REDIR:   state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cause_q <= '0;
            pc_q    <= '0;
            tval_q  <= '0;
            kind_q  <= REDIR_TRAP;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            tval_q  <= tval_d;
            kind_q  <= kind_d;
        end
    end

    // Moore outputs decoded from the current state. Write address/data and
    // redirect address are forced to zero whenever their strobe is low.
    always_comb begin
        bus.csr_we        = 1'b0;
        bus.csr_waddr     = '0;
        bus.csr_wdata     = '0;
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = '0;
        case (state_q)
            ST_KILL: begin
                bus.stall = 1'b1;
                bus.flush = 1'b1;
            end
            ST_W_EPC: begin
                bus.stall     = 1'b1;
                bus.csr_we    = 1'b1;
                bus.csr_waddr = CSR_MEPC;
                bus.csr_wdata = pc_q;
            end
            ST_W_CAUSE: begin
                bus.stall     = 1'b1;
                bus.csr_we    = 1'b1;
                bus.csr_waddr = CSR_MCAUSE;
                bus.csr_wdata = {{(XLEN-CAUSE_W){1'b0}}, cause_q};
            end
            ST_W_TVAL: begin
                bus.stall     = 1'b1;
                bus.csr_we    = 1'b1;
                bus.csr_waddr = CSR_MTVAL;
                bus.csr_wdata = tval_q;
            end
            ST_REDIR: begin
                bus.redirect = 1'b1;
                bus.flush    = 1'b1;
                // mtvec is read live: nothing in this sequence writes it.
                if (kind_q == REDIR_MRET) begin
                    bus.redirect_addr = {bus.csr_mepc[XLEN-1:1], 1'b0};
                end else begin
                    bus.redirect_addr = {bus.csr_mtvec[XLEN-1:2], 2'b00};
                end
            end
            default: ;
        endcase
    end

    assign bus.busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_trap_sequencer
//  Self-checking bench. The reference model is a schedule of expected
//  per-cycle output records: accepting a request while idle appends the whole
//  sequence of records at once; each clock edge consumes one record; reset
//  discards the schedule. Outputs are compared every cycle, #1 after the edge.
// ---------------------------------------------------------------------------
module tb_trap_sequencer;

    localparam int NS = 3;
    localparam int CW = 5;
    localparam int XL = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    trap_sequencer_if #(.NUM_SRC(NS), .CAUSE_W(CW), .XLEN(XL)) bus ();

    trap_sequencer #(.NUM_SRC(NS), .CAUSE_W(CW), .XLEN(XL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        bit        stall;
        bit        flush;
        bit        we;
        bit [11:0] addr;
        bit [31:0] data;
        bit        redir;
        int        kind;   // 0 none, 1 trap (mtvec), 2 mret (mepc)
    } rec_t;

    rec_t sched[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [11:0] waddr_log[$];
    logic [31:0] wdata_log[$];
    int          redir_count;
    int          redir_cyc;
    logic [31:0] redir_addr;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, exp);
        end
    endtask

    function automatic rec_t mk(bit st, bit fl, bit we, bit [11:0] a, bit [31:0] d, bit rd, int k);
        rec_t r;
        r.stall = st; r.flush = fl; r.we = we; r.addr = a; r.data = d; r.redir = rd; r.kind = k;
        return r;
    endfunction

    // Model update at a rising edge, from the inputs present at that edge.
    task automatic model_edge();
        if (reset) begin
            sched.delete();
        end else if (sched.size() > 0) begin
            void'(sched.pop_front());
        end else if (bus.exc_valid != '0) begin
            int w;
            logic [31:0] pc, tv;
            logic [4:0]  ca;
            w = 0;
            for (int i = 0; i < NS; i++) if (bus.exc_valid[i]) w = i;
            pc = bus.exc_pc[w*XL +: XL];
            tv = bus.exc_tval[w*XL +: XL];
            ca = bus.exc_cause[w*CW +: CW];
            sched.push_back(mk(1, 1, 0, 12'h000, 32'h0, 0, 0));
            sched.push_back(mk(1, 0, 1, 12'h341, pc, 0, 0));
            sched.push_back(mk(1, 0, 1, 12'h342, 32'(ca), 0, 0));
            sched.push_back(mk(1, 0, 1, 12'h343, tv, 0, 0));
            sched.push_back(mk(0, 1, 0, 12'h000, 32'h0, 1, 1));
        end else if (bus.mret_valid) begin
            sched.push_back(mk(0, 1, 0, 12'h000, 32'h0, 1, 2));
        end
    endtask

    task automatic check_outputs();
        rec_t e;
        logic [31:0] ea;
        if (sched.size() > 0) e = sched[0];
        else                  e = mk(0, 0, 0, 12'h000, 32'h0, 0, 0);
        if (e.kind == 1)      ea = bus.csr_mtvec & ~32'h3;
        else if (e.kind == 2) ea = bus.csr_mepc & ~32'h1;
        else                  ea = 32'h0;
        chk("stall",         32'(bus.stall),     32'(e.stall));
        chk("flush",         32'(bus.flush),     32'(e.flush));
        chk("csr_we",        32'(bus.csr_we),    32'(e.we));
        chk("csr_waddr",     32'(bus.csr_waddr), 32'(e.addr));
        chk("csr_wdata",     bus.csr_wdata,      e.data);
        chk("redirect",      32'(bus.redirect),  32'(e.redir));
        chk("redirect_addr", bus.redirect_addr,  ea);
        chk("busy",          32'(bus.busy),      32'(sched.size() > 0));
        if (bus.csr_we === 1'b1) begin
            waddr_log.push_back(bus.csr_waddr);
            wdata_log.push_back(bus.csr_wdata);
        end
        if (bus.redirect === 1'b1) begin
            redir_count++;
            redir_cyc  = cyc;
            redir_addr = bus.redirect_addr;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic clear_logs();
        waddr_log.delete();
        wdata_log.delete();
        redir_count = 0;
        redir_cyc   = -1;
        redir_addr  = '0;
    endtask

    task automatic idle_inputs();
        bus.exc_valid  = '0;
        bus.mret_valid = 1'b0;
    endtask

    task automatic set_src(input int i, input logic [4:0] c, input logic [31:0] pc, input logic [31:0] tv);
        bus.exc_cause[i*CW +: CW] = c;
        bus.exc_pc[i*XL +: XL]    = pc;
        bus.exc_tval[i*XL +: XL]  = tv;
    endtask

    int t0;

    initial begin
        reset         = 1'b1;
        bus.exc_valid = '0;
        bus.exc_cause = '0;
        bus.exc_pc    = '0;
        bus.exc_tval  = '0;
        bus.mret_valid = 1'b0;
        bus.csr_mtvec = '0;
        bus.csr_mepc  = '0;
        clear_logs();
        #1;
        step();
        step();
        chk("rst_busy",  32'(bus.busy),     32'h0);
        chk("rst_stall", 32'(bus.stall),    32'h0);
        chk("rst_we",    32'(bus.csr_we),   32'h0);
        reset = 1'b0;

        // 1: single exception from source 0
        clear_logs();
        bus.csr_mtvec = 32'h200;
        set_src(0, 5'd2, 32'h100, 32'hDEAD);
        bus.exc_valid = 3'b001;
        t0 = cyc;
        step();
        idle_inputs();
        chk("t1_stall_c1", 32'(bus.stall), 32'h1);
        for (int k = 2; k <= 6; k++) begin
            step();
            chk("t1_stall", 32'(bus.stall), 32'(k <= 4));
        end
        chk("t1_nwr",   32'(waddr_log.size()), 32'd3);
        chk("t1_a0",    32'(waddr_log[0]), 32'h341);
        chk("t1_d0",    wdata_log[0],      32'h100);
        chk("t1_a1",    32'(waddr_log[1]), 32'h342);
        chk("t1_d1",    wdata_log[1],      32'h2);
        chk("t1_a2",    32'(waddr_log[2]), 32'h343);
        chk("t1_d2",    wdata_log[2],      32'hDEAD);
        chk("t1_rcyc",  32'(redir_cyc - t0), 32'd5);
        chk("t1_raddr", redir_addr,        32'h200);

        // 2: src0 and src2 together -> src2 wins
        clear_logs();
        set_src(0, 5'd2, 32'h111, 32'h1);
        set_src(2, 5'd4, 32'h300, 32'h2);
        bus.exc_valid = 3'b101;
        step();
        idle_inputs();
        repeat (5) step();
        chk("t2_mepc",   wdata_log[0], 32'h300);
        chk("t2_mcause", wdata_log[1], 32'h4);

        // 3: MRET
        clear_logs();
        bus.csr_mepc   = 32'h1235;
        bus.mret_valid = 1'b1;
        step();
        idle_inputs();
        chk("t3_redir", 32'(bus.redirect),  32'h1);
        chk("t3_addr",  bus.redirect_addr,  32'h1234);
        chk("t3_stall", 32'(bus.stall),     32'h0);
        chk("t3_we",    32'(bus.csr_we),    32'h0);
        step();
        chk("t3_busy",  32'(bus.busy),      32'h0);
        chk("t3_nwr",   32'(waddr_log.size()), 32'd0);

        // 4: exception with simultaneous MRET; pulse during W_CAUSE ignored
        clear_logs();
        set_src(1, 5'd7, 32'h404, 32'h55);
        bus.exc_valid  = 3'b010;
        bus.mret_valid = 1'b1;
        step();                     // KILL
        idle_inputs();
        step();                     // W_EPC
        step();                     // W_CAUSE
        bus.exc_valid = 3'b100;
        step();                     // W_TVAL
        idle_inputs();
        step();                     // REDIR
        step();                     // IDLE
        chk("t4_nwr",   32'(waddr_log.size()), 32'd3);
        chk("t4_mepc",  wdata_log[0], 32'h404);
        chk("t4_nred",  32'(redir_count), 32'd1);
        chk("t4_raddr", redir_addr, 32'h200);
        chk("t4_idle",  32'(bus.busy), 32'h0);

        // 5: reset in W_CAUSE
        clear_logs();
        set_src(0, 5'd3, 32'h500, 32'h77);
        bus.exc_valid = 3'b001;
        step();                     // KILL
        idle_inputs();
        step();                     // W_EPC
        step();                     // W_CAUSE
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_busy",  32'(bus.busy),  32'h0);
        chk("t5_we",    32'(bus.csr_we), 32'h0);
        chk("t5_stall", 32'(bus.stall), 32'h0);
        repeat (4) step();
        chk("t5_nwr",   32'(waddr_log.size()), 32'd2);

        // 6: back-to-back with held request, mtvec low bits masked
        clear_logs();
        bus.csr_mtvec = 32'h203;
        set_src(0, 5'd1, 32'h600, 32'h88);
        bus.exc_valid = 3'b001;
        repeat (5) step();
        chk("t6_redir", 32'(bus.redirect), 32'h1);
        chk("t6_raddr", bus.redirect_addr, 32'h200);
        step();
        chk("t6_gap",   32'(bus.busy),  32'h0);
        step();
        chk("t6_kill",  32'(bus.flush & bus.stall), 32'h1);
        idle_inputs();
        repeat (5) step();
        chk("t6_nred",  32'(redir_count), 32'd2);

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset          = ($urandom_range(0, 199) == 0);
            bus.exc_valid  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            bus.mret_valid = ($urandom_range(0, 5) == 0);
            bus.exc_cause  = 15'($urandom);
            bus.exc_pc     = {$urandom, $urandom, $urandom};
            bus.exc_tval   = {$urandom, $urandom, $urandom};
            bus.csr_mtvec  = $urandom;
            bus.csr_mepc   = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
